// File: rtl/atmos_light_est.sv
// Per-frame atmospheric light estimator: tracks the brightest dark-channel pixel of each
// frame, clamps its max(R,G,B) and blends it into post_A with a first-order IIR at frame end.
module atmos_light_est #(
  parameter logic [7:0]  A_MIN        = 8'd26,
  parameter logic [7:0]  A_MAX        = 8'd240,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter logic [7:0]  A_INIT       = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_href,
  input  logic        pre_frame_clken,
  input  logic [7:0]  pre_dark,
  input  logic [23:0] pre_rgb,
  output logic [7:0]  post_A,
  output logic        post_A_valid,
  output logic        frame_done
);

  logic              r_vsync_d1;
  logic              r_started;
  logic              r_armed;
  logic              r_seen;
  logic [7:0]        r_max_dark;
  logic [7:0]        r_cand;

  logic              w_rise;
  logic              w_fall;
  logic              w_accept;
  logic              w_seen_eff;
  logic              w_take;
  logic [7:0]        w_rg_max;
  logic [7:0]        w_rgb_max;
  logic [7:0]        w_clamped;
  logic signed [8:0] w_diff;
  logic signed [8:0] w_step;
  logic [7:0]        w_smoothed;
  logic              w_unused;

  // Line valid carries no information the pixel strobe does not already give.
  assign w_unused = pre_frame_href;

  // r_started masks the first cycle after reset so a frame already in flight
  // at reset release is never mistaken for a fresh frame start.
  assign w_rise   = pre_frame_vsync & ~r_vsync_d1 & r_started;
  assign w_fall   = ~pre_frame_vsync & r_vsync_d1;
  assign w_accept = pre_frame_clken & pre_frame_vsync;

  // A rise clears the tracker, so a pixel arriving on that same cycle competes
  // against an empty tracker.
  assign w_seen_eff = r_seen & ~w_rise;
  assign w_take     = w_accept & (~w_seen_eff | (pre_dark > r_max_dark));

  assign w_rg_max  = (pre_rgb[23:16] > pre_rgb[15:8]) ? pre_rgb[23:16] : pre_rgb[15:8];
  assign w_rgb_max = (w_rg_max > pre_rgb[7:0]) ? w_rg_max : pre_rgb[7:0];

  // Clamping at capture time keeps the frame-end path to subtract/shift/add only.
  always_comb begin
    w_clamped = w_rgb_max;
    if (w_rgb_max < A_MIN) begin
      w_clamped = A_MIN;
    end else if (w_rgb_max > A_MAX) begin
      w_clamped = A_MAX;
    end
  end

  // The blended value lies between old and candidate, so 8-bit wraparound is exact.
  assign w_diff     = $signed({1'b0, r_cand}) - $signed({1'b0, post_A});
  assign w_step     = w_diff >>> SMOOTH_SHIFT;
  assign w_smoothed = post_A + w_step[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d1 <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      r_vsync_d1 <= pre_frame_vsync;
      r_started  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen     <= 1'b0;
      r_max_dark <= 8'd0;
      r_cand     <= 8'd0;
    end else if (w_take) begin
      r_seen     <= 1'b1;
      r_max_dark <= pre_dark;
      r_cand     <= w_clamped;
    end else if (w_rise) begin
      r_seen     <= 1'b0;
      r_max_dark <= 8'd0;
      r_cand     <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed      <= 1'b0;
      post_A       <= A_INIT;
      post_A_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (w_rise) begin
        r_armed <= 1'b1;
      end else if (w_fall && r_armed) begin
        r_armed    <= 1'b0;
        frame_done <= 1'b1;
        if (r_seen) begin
          post_A_valid <= 1'b1;
          post_A       <= post_A_valid ? w_smoothed : r_cand;
        end
      end
    end
  end

endmodule

// File: tb/tb_atmos_light_est.sv
// Bench for atmos_light_est: directed frames with literal expectations plus randomized
// frames, all checked every cycle against a frame-level behavioural model.
module tb_atmos_light_est;

  logic        clk;
  logic        rst_n;
  logic        pre_frame_vsync;
  logic        pre_frame_href;
  logic        pre_frame_clken;
  logic [7:0]  pre_dark;
  logic [23:0] pre_rgb;
  logic [7:0]  post_A;
  logic        post_A_valid;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  atmos_light_est dut (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(pre_frame_vsync), .pre_frame_href(pre_frame_href),
    .pre_frame_clken(pre_frame_clken), .pre_dark(pre_dark), .pre_rgb(pre_rgb),
    .post_A(post_A), .post_A_valid(post_A_valid), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame start/end bookkeeping and the brightest-dark pixel.
  int m_A, m_valid, m_done, m_armed, m_have, m_best_dark, m_best_max;
  int m_prev_v, m_prev_known;

  function automatic int max3(input logic [23:0] rgb);
    int r, g, b, m;
    r = int'(rgb[23:16]); g = int'(rgb[15:8]); b = int'(rgb[7:0]);
    m = r;
    if (g > m) m = g;
    if (b > m) m = b;
    return m;
  endfunction

  function automatic int floor_div(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_A = 255; m_valid = 0; m_done = 0; m_armed = 0; m_have = 0;
      m_best_dark = 0; m_best_max = 0; m_prev_v = 0; m_prev_known = 0;
    end else begin
      int cand;
      m_done = 0;
      if (pre_frame_vsync && m_prev_known != 0 && m_prev_v == 0) begin
        m_armed = 1;
        m_have = 0;
      end
      if (pre_frame_vsync && pre_frame_clken && (m_have == 0 || int'(pre_dark) > m_best_dark)) begin
        m_best_dark = int'(pre_dark);
        m_best_max = max3(pre_rgb);
        m_have = 1;
      end
      if (!pre_frame_vsync && m_prev_v != 0 && m_armed != 0) begin
        m_armed = 0;
        m_done = 1;
        if (m_have != 0) begin
          cand = m_best_max < 26 ? 26 : (m_best_max > 240 ? 240 : m_best_max);
          if (m_valid == 0) m_A = cand;
          else m_A = m_A + floor_div(cand - m_A, 4);
          m_valid = 1;
        end
      end
      m_prev_v = pre_frame_vsync ? 1 : 0;
      m_prev_known = 1;
    end
  end

  always @(negedge clk) begin
    chk("post_A", int'(post_A), m_A);
    chk("post_A_valid", int'(post_A_valid), m_valid);
    chk("frame_done", int'(frame_done), m_done);
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ce, input logic [7:0] d, input logic [23:0] rgb);
    pre_frame_vsync = v;
    pre_frame_clken = ce;
    pre_frame_href  = ce;
    pre_dark        = d;
    pre_rgb         = rgb;
    cyc();
  endtask

  // 4x4 frame, background dark=10, one peak pixel at position idx.
  task automatic frame_peak(input logic [7:0] pd, input logic [23:0] prgb, input int idx);
    drive(1'b1, 1'b0, 8'd0, 24'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == idx) drive(1'b1, 1'b1, pd, prgb);
      else drive(1'b1, 1'b1, 8'd10, 24'($urandom));
    end
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    drive(1'b0, 1'b0, 8'd0, 24'd0);
  endtask

  task automatic reset_idle();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 24'd0);
  endtask

  int d0;

  initial begin
    rst_n = 1'b0;
    pre_frame_vsync = 1'b0; pre_frame_href = 1'b0; pre_frame_clken = 1'b0;
    pre_dark = 8'd0; pre_rgb = 24'd0;
    cyc(); cyc();
    chk("reset_A", int'(post_A), 255);
    chk("reset_valid", int'(post_A_valid), 0);
    chk("reset_done", int'(frame_done), 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 24'd0);

    d0 = done_cnt;
    frame_peak(8'd200, 24'h50B43C, 6);
    chk("first_frame_A", int'(post_A), 180);
    chk("first_frame_valid", int'(post_A_valid), 1);
    chk("first_frame_done_count", done_cnt - d0, 1);

    frame_peak(8'd200, 24'h643210, 3);
    chk("smooth_down_A", int'(post_A), 160);
    frame_peak(8'd200, 24'hA20000, 9);
    chk("smooth_small_up_A", int'(post_A), 160);
    frame_peak(8'd200, 24'h9D0000, 0);
    chk("smooth_small_down_A", int'(post_A), 159);

    d0 = done_cnt;
    drive(1'b1, 1'b0, 8'd0, 24'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'd255, 24'hFFFFFF);
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    chk("empty_frame_done_count", done_cnt - d0, 1);
    chk("empty_frame_A", int'(post_A), 159);

    // Pixel presented on the fall cycle must not be considered.
    drive(1'b1, 1'b0, 8'd0, 24'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'd100, 24'h9F0000);
    drive(1'b0, 1'b1, 8'd250, 24'hFFFFFF);
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    chk("fall_pixel_ignored_A", int'(post_A), 159);

    // Asynchronous reset mid-frame.
    drive(1'b1, 1'b0, 8'd0, 24'd0);
    drive(1'b1, 1'b1, 8'd200, 24'hC0C0C0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_A", int'(post_A), 255);
    chk("async_reset_valid", int'(post_A_valid), 0);
    chk("async_reset_done", int'(frame_done), 0);
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 24'd0);

    // Tie on dark: the first pixel wins.
    drive(1'b1, 1'b0, 8'd0, 24'd0);
    drive(1'b1, 1'b1, 8'd150, 24'h5A0000);
    drive(1'b1, 1'b1, 8'd150, 24'h007800);
    drive(1'b1, 1'b1, 8'd20, 24'hFF0000);
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    drive(1'b0, 1'b0, 8'd0, 24'd0);
    chk("tie_first_wins_A", int'(post_A), 90);

    reset_idle();
    frame_peak(8'd200, 24'hFFFFFF, 5);
    chk("clamp_high_A", int'(post_A), 240);
    reset_idle();
    frame_peak(8'd200, 24'h050505, 5);
    chk("clamp_low_A", int'(post_A), 26);

    // Reset released while a frame is already in progress.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'd0, 24'd0);
    rst_n = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'd200, 24'h808080);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'd0, 24'd0);
    chk("partial_frame_done_count", done_cnt - d0, 0);
    chk("partial_frame_A", int'(post_A), 255);
    chk("partial_frame_valid", int'(post_A_valid), 0);
    frame_peak(8'd200, 24'h50B43C, 2);
    chk("after_partial_A", int'(post_A), 180);

    // Randomized frames, including one-cycle gaps and fall-cycle strobes.
    for (int f = 0; f < 60; f++) begin
      int len, gap, mode;
      len  = int'($urandom_range(1, 40));
      gap  = int'($urandom_range(1, 4));
      mode = int'($urandom_range(0, 3));
      for (int c = 0; c < len; c++) begin
        logic [7:0] d;
        if (mode == 0) d = 8'($urandom_range(0, 3) * 64);
        else d = 8'($urandom);
        drive(1'b1, (mode == 3) ? 1'b0 : 1'($urandom), d, 24'($urandom));
      end
      for (int c = 0; c < gap; c++) drive(1'b0, 1'($urandom), 8'($urandom), 24'($urandom));
    end
    drive(1'b0, 1'b0, 8'd0, 24'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/atmos_light_est.md
Name: atmos_light_est

Overview:
- Estimates atmospheric light A once per frame from the dark-channel stream and the aligned source RGB stream.
- Sits directly upstream of the haze-removal arithmetic stage and drives its 8-bit A input.
- Holds A stable for the whole following frame.
- Applies clamping and first-order IIR smoothing across frames to suppress flicker.

Parameters:
- A_MIN, 8'd26: lower clamp on the per-frame candidate A.
- A_MAX, 8'd240: upper clamp on the per-frame candidate A.
- SMOOTH_SHIFT, 2: IIR weight exponent, range 0..7. 0 = direct load every frame.
- A_INIT, 8'd255: post_A value after reset, before the first accepted frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pre_frame_vsync  in  1  frame valid, high for the whole active frame
- pre_frame_href  in  1  line valid
- pre_frame_clken  in  1  pixel strobe; dark and rgb are valid when high
- pre_dark  in  8  dark-channel value of the current pixel
- pre_rgb  in  24  source pixel aligned with pre_dark, {R[23:16], G[15:8], B[7:0]}
- post_A  out  8  current atmospheric light
- post_A_valid  out  1  high once at least one frame has been accepted since reset
- frame_done  out  1  one-cycle pulse when a frame's A update is committed

Behaviour:
- Reset (async, rst_n low): post_A=A_INIT, post_A_valid=0, frame_done=0. Tracker, candidate, armed flag, pixel-seen flag and vsync delay all cleared.
- Edge detection uses vsync_d1, the registered copy of pre_frame_vsync.
  - Rise: vsync=1 and vsync_d1=0. Sets armed=1 and clears the tracker (max_dark=0, cand_rgbmax=0, seen=0).
  - Fall: vsync=0 and vsync_d1=1. This is cycle k.
- Pixel accept condition: clken=1 and vsync=1. href is not used for qualification.
  - On an accepted pixel where pre_dark > max_dark (strict, so the first occurrence wins ties, or when seen=0): max_dark <= pre_dark, cand_rgbmax <= max(R,G,B), seen <= 1.
- Partial frames: a frame already in progress at reset release has no rise, so armed=0 and its fall is ignored. No update, no frame_done.
- Cycle k (fall, armed=1):
  - Register a_cand = clamp(cand_rgbmax, A_MIN, A_MAX).
  - Latch upd = seen.
  - Clear armed.
  - Pixels with vsync=0 at cycle k are ignored.
- Cycle k+1:
  - frame_done=1 for exactly one cycle.
  - If upd=1 and post_A_valid=0: post_A <= a_cand, post_A_valid <= 1.
  - If upd=1 and post_A_valid=1: diff = signed 9-bit (a_cand − post_A); post_A <= post_A + (diff >>> SMOOTH_SHIFT). The shift is arithmetic, rounding toward −inf. The result is always within [min(old, cand), max(old, cand)], so no overflow.
  - If upd=0 (empty frame): post_A and post_A_valid unchanged; frame_done still pulses.
- post_A changes only at cycle k+1. It is constant for the whole next frame.
- A rise at k+1 (one-cycle vsync gap) is legal: the tracker clear and the commit happen in the same cycle without interaction.
- Vsync low for one cycle mid-frame counts as a frame boundary. There is no glitch filtering.

Test Plan:
- Frame of 4x4 pixels, dark all 10 except pixel 6 with dark=200 and rgb=0x50B43C -> frame_done at k+1; post_A=0xB4 (180); post_A_valid rises at k+1.
- Second frame, peak pixel rgbmax=100, post_A=180, SMOOTH_SHIFT=2 -> diff=−80; post_A=160. Third frame candidate 162 -> post_A=160; candidate 157 -> post_A=159.
- Clamping: peak rgb=0xFFFFFF -> post_A=240 (first frame). Peak rgb=0x050505 on a fresh reset -> post_A=26.
- Ties: two pixels both dark=150 with rgbmax 90 then 120 -> post_A=90. Empty frame (vsync high, no clken) -> frame_done pulses, post_A unchanged.
- Release rst_n mid-frame, then vsync falls -> no frame_done, post_A=A_INIT=255, valid=0. The next full frame updates normally.
- Assert rst_n low mid-frame after valid -> outputs return to 255/0/0 asynchronously. A pixel with clken=1 on the fall cycle and dark=250 -> ignored.
